pe_inject_ni: RTL and testbench
===============================

Name: pe_inject_ni

Overview:
- Network-interface injection stage directly downstream of the bitwise processing elements (AND/OR/etc.).
- Captures each 71-bit result flit the PE presents with its one-cycle send pulse and buffers it in a small FIFO.
- Injects buffered flits into the router's local input port in strict order under per-VC credit flow control.
- Decouples PE bursts from router back-pressure; no flit is lost unless the FIFO is full.

Parameters:
- FIFO_DEPTH, 4, injection FIFO entries (power of two, >=2)
- VC_CREDITS, 2, router input-buffer slots per VC; reset value and ceiling of each credit counter
- FLIT_W, 71, flit width: [70] valid, [69] head/tail, [68:65] dest, [64] vc, [63:0] payload

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pe_flit  in  FLIT_W  result flit from PE
- pe_send  in  1  one-cycle pulse qualifying pe_flit
- out_flit  out  FLIT_W  flit to router local port (registered)
- out_valid  out  1  out_flit valid this cycle
- credit_in  in  2  one-cycle credit return per VC (bit i = VC i)
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
- overflow  out  1  sticky: a flit was dropped on a full FIFO
- credit_err  out  1  sticky: credit returned while counter at VC_CREDITS
- drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset, asynchronous, rst_n low:
  - out_flit=0, out_valid=0, fifo_count=0, overflow=0, credit_err=0, drop_cnt=0.
  - Both credit counters = VC_CREDITS; FIFO pointers = 0.
  - Reset asserted mid-operation discards all buffered flits immediately.
- Push:
  - Condition: pe_send=1 and pe_flit[70]=1 and (not full or a pop occurs in the same cycle).
  - pe_send with pe_flit[70]=0 is ignored: no push, no drop.
- Drop:
  - Condition: push condition fails only because the FIFO is full.
  - Effect: flit discarded, overflow set, drop_cnt+1 saturating at 255.
- Pop:
  - Condition: FIFO not empty and credit[head.vc] > 0.
  - Effect: head loaded into out_flit, out_valid=1 next cycle, credit[head.vc] decremented.
- Output:
  - out_valid is a single-cycle pulse per flit.
  - out_flit holds its last value when out_valid=0; it is not re-zeroed.
- Latency: a flit pushed in cycle N into an empty FIFO with credit available pops in cycle N+1 and shows out_valid in cycle N+2.
- Ordering: strict FIFO, no VC bypass. A head flit blocked on zero credit stalls all later flits, including those on the other VC.
- Throughput: one flit per cycle when credits allow.
- Credits:
  - credit_in[i] increments credit[i].
  - Pop decrement and return on the same VC in the same cycle: counter unchanged.
  - Return with counter already at VC_CREDITS and no same-cycle decrement: counter unchanged, credit_err set.
- Push and pop in the same cycle: fifo_count unchanged. This is legal when full (the pop frees the slot).
- Pointers wrap modulo FIFO_DEPTH. fifo_count distinguishes full from empty.
- Control states: IDLE (empty), SEND (head has credit), STALL (head lacks credit).
  - IDLE -> SEND on push.
  - SEND -> STALL when credit[head.vc] reaches 0.
  - STALL -> SEND on a credit return for head.vc.
  - Any state -> IDLE when the last entry pops with no push.
- Flit contents pass unmodified; dest and vc are read from the head entry, never from pe_flit.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W; bit positions FLIT_VALID=70, FLIT_HT=69, DEST_HI=68, DEST_LO=65, FLIT_VC=64.
  - NUM_VC=2; flit typedef.
  - Control-state enum {IDLE, SEND, STALL}.
- One natural sub-module, flit_fifo: synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- Credit counters and the control FSM live in pe_inject_ni.

Test Plan:
1. Single flit: reset, then pe_send with pe_flit={1,1,4'b0101,0,64'h6} -> out_valid one cycle at N+2, out_flit equal to input, credit[0]=1.
2. Credit stall: three VC0 flits, no credit_in -> two injected, third held, fifo_count=1. Then credit_in=2'b01 -> third injected on the cycle after next.
3. HOL blocking: VC0 credits exhausted, head VC0, next flit VC1 -> no output until a VC0 credit returns; then VC0 flit first, VC1 flit next cycle.
4. Overflow: block with zero credits, push 6 flits into FIFO_DEPTH=4 -> fifo_count=4, overflow=1, drop_cnt=2. Return credits -> first four injected in order.
5. Simultaneous: full FIFO with credit available, pe_send in the same cycle as a pop -> flit accepted, drop_cnt unchanged, count stays 4. Also credit_in[0] during a VC0 pop -> counter unchanged.
6. Reset mid-burst: rst_n low with 3 flits buffered -> outputs 0 asynchronously. After release, credits=2 each, no stale flit emitted. A credit_in at full credits then sets credit_err=1.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: flit layout, VC count and injection control states shared across the NoC slice.
package noc_pkg;
  localparam int FLIT_W = 71;
  localparam int FLIT_VALID = 70;
  localparam int FLIT_HT = 69;
  localparam int DEST_HI = 68;
  localparam int DEST_LO = 65;
  localparam int FLIT_VC = 64;
  localparam int NUM_VC = 2;
  typedef logic [FLIT_W-1:0] flit_t;
  typedef enum logic [1:0] {IDLE, SEND, STALL} ctrl_state_t;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous flit FIFO exposing the head entry and the entry behind it.
module flit_fifo #(
  parameter int W = 71,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [W-1:0]               head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/pe_inject_ni.sv
// pe_inject_ni: buffers PE result flits and injects them in order into the router
// local port under per-VC credit flow control.
module pe_inject_ni #(
  parameter int FIFO_DEPTH = 4,
  parameter int VC_CREDITS = 2,
  parameter int FLIT_W = 71
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [FLIT_W-1:0]               pe_flit,
  input  logic                            pe_send,
  output logic [FLIT_W-1:0]               out_flit,
  output logic                            out_valid,
  input  logic [1:0]                      credit_in,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic                            credit_err,
  output logic [7:0]                      drop_cnt
);
  import noc_pkg::*;
  localparam int CW = $clog2(VC_CREDITS+1);
  localparam int NW = $clog2(FIFO_DEPTH+1);
  logic [FLIT_W-1:0] head, head_next;
  logic full, empty, valid_in, push, pop, drop, hv, nhv;
  logic [NUM_VC-1:0] dec, cerr;
  logic [CW-1:0] cr [NUM_VC];
  logic [CW-1:0] cr_n [NUM_VC];
  logic [NW-1:0] cnt_n;
  ctrl_state_t state, state_n;
  flit_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pe_flit),
    .head(head), .head_next(head_next), .full(full), .empty(empty), .count(fifo_count)
  );
  // SEND is registered as "head has credit", so it directly qualifies the pop.
  always_comb begin
    valid_in = pe_send & pe_flit[FLIT_VALID];
    pop = (state == SEND) & !empty;
    push = valid_in & (!full | pop);
    drop = valid_in & full & !pop;
    hv = head[FLIT_VC];
    nhv = (fifo_count == '0 || (pop && fifo_count == NW'(1))) ? pe_flit[FLIT_VC]
        : pop ? head_next[FLIT_VC] : hv;
    cnt_n = fifo_count + NW'(push) - NW'(pop);
    dec = '0;
    cerr = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      dec[i] = pop & (hv == 1'(i));
      cerr[i] = credit_in[i] & !dec[i] & (cr[i] == CW'(VC_CREDITS));
      cr_n[i] = (credit_in[i] & !dec[i]) ? (cerr[i] ? cr[i] : cr[i] + CW'(1))
              : (dec[i] & !credit_in[i]) ? cr[i] - CW'(1) : cr[i];
    end
    state_n = cnt_n == '0 ? IDLE : cr_n[nhv] != '0 ? SEND : STALL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flit <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
      credit_err <= 1'b0;
      drop_cnt <= '0;
      state <= IDLE;
      for (int i = 0; i < NUM_VC; i++) cr[i] <= CW'(VC_CREDITS);
    end else begin
      out_valid <= pop;
      if (pop) out_flit <= head;
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (|cerr) credit_err <= 1'b1;
      state <= state_n;
      for (int i = 0; i < NUM_VC; i++) cr[i] <= cr_n[i];
    end
  end
endmodule

// File: tb/tb_pe_inject_ni.sv
// tb_pe_inject_ni: directed and random stimulus checked against a queue-based model.
module tb_pe_inject_ni;
  logic clk, rst_n, pe_send, out_valid, overflow, credit_err;
  logic [70:0] pe_flit, out_flit;
  logic [1:0] credit_in;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;
  int n_assert = 0, n_fail = 0;
  logic [70:0] q[$];
  int cred[2];
  logic [70:0] e_flit;
  logic e_valid, e_ovf, e_cerr;
  int e_drop;

  pe_inject_ni dut (
    .clk(clk), .rst_n(rst_n), .pe_flit(pe_flit), .pe_send(pe_send),
    .out_flit(out_flit), .out_valid(out_valid), .credit_in(credit_in),
    .fifo_count(fifo_count), .overflow(overflow), .credit_err(credit_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] mk(input logic vc, input logic [3:0] dest, input logic [63:0] pl);
    return {1'b1, 1'b1, dest, vc, pl};
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 71'(out_valid), 71'(e_valid));
    chk("out_flit", out_flit, e_flit);
    chk("fifo_count", 71'(fifo_count), 71'(q.size()));
    chk("overflow", 71'(overflow), 71'(e_ovf));
    chk("credit_err", 71'(credit_err), 71'(e_cerr));
    chk("drop_cnt", 71'(drop_cnt), 71'(e_drop));
  endtask

  task automatic mreset();
    q.delete();
    cred[0] = 2;
    cred[1] = 2;
    e_flit = '0;
    e_valid = 0;
    e_ovf = 0;
    e_cerr = 0;
    e_drop = 0;
  endtask

  task automatic model();
    logic pop, push, vin;
    int pvc;
    pvc = -1;
    pop = q.size() > 0 && cred[q[0][64]] > 0;
    vin = pe_send && pe_flit[70];
    push = vin && (q.size() < 4 || pop);
    e_valid = pop;
    if (pop) begin
      e_flit = q.pop_front();
      pvc = int'(e_flit[64]);
    end
    for (int i = 0; i < 2; i++) begin
      if (credit_in[i]) begin
        if (pvc == i) ;
        else if (cred[i] == 2) e_cerr = 1;
        else cred[i]++;
      end else if (pvc == i) cred[i]--;
    end
    if (push) q.push_back(pe_flit);
    else if (vin) begin
      e_ovf = 1;
      if (e_drop < 255) e_drop++;
    end
  endtask

  task automatic step(input logic s, input logic [70:0] f, input logic [1:0] c);
    pe_send = s;
    pe_flit = f;
    credit_in = c;
    @(posedge clk);
    model();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 2'b00);
  endtask

  task automatic restore();
    for (int i = 0; i < 20 && (cred[0] < 2 || cred[1] < 2 || q.size() > 0); i++)
      step(0, '0, {cred[1] < 2, cred[0] < 2});
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    pe_send = 0;
    pe_flit = '0;
    credit_in = '0;
    mreset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1;
    step(1, mk(0, 4'b0101, 64'h6), 2'b00);
    idle(3);
    restore();
    for (int i = 0; i < 3; i++) step(1, mk(0, 4'(i), 64'(100 + i)), 2'b00);
    idle(4);
    step(0, '0, 2'b01);
    idle(3);
    restore();
    step(1, mk(0, 4'h1, 64'hA1), 2'b00);
    step(1, mk(0, 4'h2, 64'hA2), 2'b00);
    step(1, mk(0, 4'h3, 64'hA3), 2'b00);
    step(1, mk(1, 4'h4, 64'hB4), 2'b00);
    idle(4);
    step(0, '0, 2'b01);
    idle(3);
    restore();
    step(1, mk(0, 4'h0, 64'hC0), 2'b00);
    step(1, mk(0, 4'h0, 64'hC1), 2'b00);
    step(1, mk(1, 4'h0, 64'hC2), 2'b00);
    step(1, mk(1, 4'h0, 64'hC3), 2'b00);
    idle(3);
    for (int i = 0; i < 6; i++) step(1, mk(0, 4'(i), 64'(200 + i)), 2'b00);
    step(1, {1'b0, 70'h3}, 2'b00);
    step(0, '0, 2'b01);
    step(1, mk(1, 4'h9, 64'hD0), 2'b00);
    step(0, '0, 2'b01);
    step(0, '0, 2'b01);
    restore();
    step(1, mk(0, 4'h0, 64'hE0), 2'b00);
    step(1, mk(0, 4'h0, 64'hE1), 2'b00);
    step(1, mk(1, 4'h0, 64'hE2), 2'b00);
    step(1, mk(1, 4'h0, 64'hE3), 2'b00);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, mk(i[0], 4'(i), 64'(300 + i)), 2'b00);
    #2;
    rst_n = 0;
    #1;
    mreset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(3);
    step(0, '0, 2'b01);
    for (int n = 0; n < 400; n++) begin
      logic [70:0] f;
      logic [1:0] c;
      f = {$urandom_range(0, 7) != 0, 1'($urandom), 4'($urandom), 1'($urandom), $urandom, $urandom};
      for (int i = 0; i < 2; i++)
        c[i] = cred[i] < 2 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 49) == 0;
      step($urandom_range(0, 3) != 0, f, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
